// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle MIPS sequencing controller with memory handshake timeout
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_eq_o,
    output logic       pc_write_ne_o,
    output logic [1:0] pc_source_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic [3:0] state_o,
    output logic       instr_done_o,
    output logic       illegal_op_o,
    output logic       bus_error_o
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_IMM_EXEC  = 4'd10,
        S_IMM_WB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_LUI   = 3'b101;

    localparam int            CW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          illegal_q, bus_error_q, illegal_nxt;
    logic          in_wait, stall, timeout;

    // The counter only runs while an access is stalled; any exit or re-entry restarts it at 0.
    assign in_wait      = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    assign stall        = in_wait && !mem_ready_i;
    assign timeout      = stall && (MEM_TIMEOUT != 0) && (wait_cnt == CNT_LAST);
    assign wait_cnt_nxt = (stall && !timeout) ? wait_cnt + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_FETCH;
            wait_cnt    <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            illegal_q   <= illegal_nxt;
            bus_error_q <= timeout;
        end
    end

    always_comb begin
        state_nxt   = S_FETCH;
        illegal_nxt = 1'b0;
        case (state)
            S_FETCH:     state_nxt = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode_i)
                    OP_RTYPE:                         state_nxt = S_EXECUTE;
                    OP_LW, OP_SW:                     state_nxt = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                   state_nxt = S_BRANCH;
                    OP_J:                             state_nxt = S_JUMP;
                    OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: state_nxt = S_IMM_EXEC;
                    default: begin
                        state_nxt   = S_FETCH;
                        illegal_nxt = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR:  state_nxt = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_nxt = mem_ready_i ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_nxt = mem_ready_i ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_nxt = S_R_WB;
            S_IMM_EXEC:  state_nxt = S_IMM_WB;
            default:     state_nxt = S_FETCH;
        endcase
        if (timeout) state_nxt = S_FETCH;
    end

    always_comb begin
        pc_write_o    = 1'b0;
        pc_write_eq_o = 1'b0;
        pc_write_ne_o = 1'b0;
        pc_source_o   = 2'b00;
        i_or_d_o      = 1'b0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        ir_write_o    = 1'b0;
        reg_dst_o     = 1'b0;
        mem_to_reg_o  = 1'b0;
        reg_write_o   = 1'b0;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = 2'b00;
        alu_op_o      = ALU_ADD;
        instr_done_o  = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE:   alu_src_b_o = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            S_MEM_READ: begin
                i_or_d_o   = 1'b1;
                mem_read_o = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            S_MEM_WRITE: begin
                i_or_d_o     = 1'b1;
                mem_write_o  = 1'b1;
                instr_done_o = mem_ready_i;
            end
            S_EXECUTE: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_dst_o    = 1'b1;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o   = 1'b1;
                alu_op_o      = ALU_SUB;
                pc_source_o   = 2'b01;
                pc_write_eq_o = (opcode_i == OP_BEQ);
                pc_write_ne_o = (opcode_i == OP_BNE);
                instr_done_o  = 1'b1;
            end
            S_JUMP: begin
                pc_write_o   = 1'b1;
                pc_source_o  = 2'b10;
                instr_done_o = 1'b1;
            end
            S_IMM_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                case (opcode_i)
                    OP_ORI:  alu_op_o = ALU_OR;
                    OP_ANDI: alu_op_o = ALU_AND;
                    OP_LUI:  alu_op_o = ALU_LUI;
                    default: alu_op_o = ALU_ADD;
                endcase
            end
            S_IMM_WB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            default: ;
        endcase
        // Reset kills every strobe immediately and parks the selects at their FETCH values.
        if (!reset) begin
            pc_write_o    = 1'b0;
            pc_write_eq_o = 1'b0;
            pc_write_ne_o = 1'b0;
            pc_source_o   = 2'b00;
            i_or_d_o      = 1'b0;
            mem_read_o    = 1'b0;
            mem_write_o   = 1'b0;
            ir_write_o    = 1'b0;
            reg_dst_o     = 1'b0;
            mem_to_reg_o  = 1'b0;
            reg_write_o   = 1'b0;
            alu_src_a_o   = 1'b0;
            alu_src_b_o   = 2'b01;
            alu_op_o      = ALU_ADD;
            instr_done_o  = 1'b0;
        end
    end

    assign state_o      = state;
    assign illegal_op_o = illegal_q;
    assign bus_error_o  = bus_error_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - vector table, corner sequences and random model check of multicycle_control_fsm
module tb_multicycle_control_fsm;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode_i;
    logic       mem_ready_i;
    logic       pc_write_o, pc_write_eq_o, pc_write_ne_o;
    logic [1:0] pc_source_o;
    logic       i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
    logic       reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [2:0] alu_op_o;
    logic [3:0] state_o;
    logic       instr_done_o, illegal_op_o, bus_error_o;

    multicycle_control_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(pc_write_o), .pc_write_eq_o(pc_write_eq_o), .pc_write_ne_o(pc_write_ne_o),
        .pc_source_o(pc_source_o), .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o),
        .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .state_o(state_o),
        .instr_done_o(instr_done_o), .illegal_op_o(illegal_op_o), .bus_error_o(bus_error_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, pceq, pcne;
        logic [1:0] pcsrc;
        logic       iord, mrd, mwr, irw, rdst, m2r, rw, srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic       done;
    } ctl_t;

    typedef struct {
        logic [5:0]      op;
        int              len;
        logic [0:4][3:0] st;
        logic [2:0]      alu2;
        logic            rw_last;
        logic [4:0]      pcv_last;
        int              done;
    } vec_t;

    ctl_t act_ctl;
    assign act_ctl = {pc_write_o, pc_write_eq_o, pc_write_ne_o, pc_source_o, i_or_d_o, mem_read_o,
                      mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o,
                      alu_src_b_o, alu_op_o, instr_done_o};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic rdy, input logic [5:0] op, input logic rst);
        @(posedge clk);
        #1;
        mem_ready_i = rdy;
        opcode_i    = op;
        reset       = rst;
        @(negedge clk);
    endtask

    // Reference model: an instruction is a route of states chosen at decode; wait states hold until ready or timeout.
    int         ms, wcnt;
    logic       exp_ill, exp_berr;
    int         path[$];
    logic [5:0] legal_ops[10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0D, 6'h0C, 6'h0F};

    task automatic set_route(input logic [5:0] op);
        path.delete();
        case (op)
            6'h00:                      path = '{6, 7};
            6'h23:                      path = '{2, 3, 4};
            6'h2B:                      path = '{2, 5};
            6'h04, 6'h05:               path = '{8};
            6'h02:                      path = '{9};
            6'h08, 6'h0D, 6'h0C, 6'h0F: path = '{10, 11};
            default: ;
        endcase
    endtask

    task automatic model_step(input logic rdy, input logic [5:0] op);
        logic stl;
        stl      = (ms == 0 || ms == 3 || ms == 5) && !rdy;
        exp_ill  = 1'b0;
        exp_berr = 1'b0;
        if (stl) begin
            if (wcnt == TO - 1) begin
                exp_berr = 1'b1;
                path.delete();
                ms   = 0;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
            if (ms == 0) begin
                ms = 1;
            end else begin
                if (ms == 1) begin
                    set_route(op);
                    exp_ill = (path.size() == 0);
                end
                if (path.size() > 0) ms = path.pop_front();
                else ms = 0;
            end
        end
    endtask

    function automatic ctl_t exp_ctrl(input int s, input logic rdy, input logic [5:0] op);
        ctl_t c;
        c = '0;
        case (s)
            0:  begin c.mrd = 1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
            1:  c.srcb = 2'b11;
            2:  begin c.srca = 1; c.srcb = 2'b10; end
            3:  begin c.iord = 1; c.mrd = 1; end
            4:  begin c.m2r = 1; c.rw = 1; c.done = 1; end
            5:  begin c.iord = 1; c.mwr = 1; c.done = rdy; end
            6:  begin c.srca = 1; c.aluop = 3'b010; end
            7:  begin c.rdst = 1; c.rw = 1; c.done = 1; end
            8:  begin c.srca = 1; c.aluop = 3'b001; c.pcsrc = 2'b01;
                      c.pceq = (op == 6'h04); c.pcne = (op == 6'h05); c.done = 1; end
            9:  begin c.pcw = 1; c.pcsrc = 2'b10; c.done = 1; end
            10: begin c.srca = 1; c.srcb = 2'b10;
                      c.aluop = (op == 6'h0D) ? 3'b011 : (op == 6'h0C) ? 3'b100 :
                                (op == 6'h0F) ? 3'b101 : 3'b000; end
            11: begin c.rw = 1; c.done = 1; end
            default: ;
        endcase
        return c;
    endfunction

    vec_t tbl[11];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int         dn, bad, mw_cnt, be_cnt;
        logic       rdy;
        logic [5:0] op;
        int         mode;

        tbl[0]  = '{6'h00, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0},   3'b010, 1'b1, 5'b00000, 1};
        tbl[1]  = '{6'h23, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4},   3'b000, 1'b1, 5'b00000, 1};
        tbl[2]  = '{6'h2B, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0},   3'b000, 1'b0, 5'b00000, 1};
        tbl[3]  = '{6'h04, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0},   3'b001, 1'b0, 5'b01001, 1};
        tbl[4]  = '{6'h05, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0},   3'b001, 1'b0, 5'b00101, 1};
        tbl[5]  = '{6'h02, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0},   3'b000, 1'b0, 5'b10010, 1};
        tbl[6]  = '{6'h08, 4, {4'd0, 4'd1, 4'd10, 4'd11, 4'd0}, 3'b000, 1'b1, 5'b00000, 1};
        tbl[7]  = '{6'h0D, 4, {4'd0, 4'd1, 4'd10, 4'd11, 4'd0}, 3'b011, 1'b1, 5'b00000, 1};
        tbl[8]  = '{6'h0C, 4, {4'd0, 4'd1, 4'd10, 4'd11, 4'd0}, 3'b100, 1'b1, 5'b00000, 1};
        tbl[9]  = '{6'h0F, 4, {4'd0, 4'd1, 4'd10, 4'd11, 4'd0}, 3'b101, 1'b1, 5'b00000, 1};
        tbl[10] = '{6'h3F, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0},   3'b000, 1'b0, 5'b00000, 0};

        reset = 1'b0; mem_ready_i = 1'b1; opcode_i = 6'h00;

        // Reset held low with mem_ready high: strobes forced off, selects at FETCH values.
        cyc(1'b1, 6'h00, 1'b0);
        chk("rst_state", state_o, 0);
        chk("rst_ir_write", ir_write_o, 0);
        chk("rst_pc_write", pc_write_o, 0);
        chk("rst_mem_read", mem_read_o, 0);
        chk("rst_src_b", alu_src_b_o, 2'b01);
        chk("rst_illegal", illegal_op_o, 0);
        chk("rst_bus_error", bus_error_o, 0);

        cyc(1'b1, 6'h00, 1'b1);
        chk("first_fetch_state", state_o, 0);
        chk("first_fetch_ctl", act_ctl, exp_ctrl(0, 1'b1, 6'h00));

        foreach (tbl[i]) begin
            dn = 0;
            opcode_i = tbl[i].op;
            for (int k = 0; k < tbl[i].len; k++) begin
                if (k > 0) cyc(1'b1, tbl[i].op, 1'b1);
                chk($sformatf("vec%0d_state_c%0d", i, k), state_o, tbl[i].st[k]);
                if (k == 2) chk($sformatf("vec%0d_alu_op", i), alu_op_o, tbl[i].alu2);
                if (k == tbl[i].len - 1) begin
                    chk($sformatf("vec%0d_reg_write_last", i), reg_write_o, tbl[i].rw_last);
                    chk($sformatf("vec%0d_pc_ctl_last", i),
                        {pc_write_o, pc_write_eq_o, pc_write_ne_o, pc_source_o}, tbl[i].pcv_last);
                end
                if (reg_write_o && k != tbl[i].len - 1) dn += 100;
                dn += instr_done_o;
            end
            chk($sformatf("vec%0d_done_count", i), dn, tbl[i].done);
            cyc(1'b1, tbl[i].op, 1'b1);
            chk($sformatf("vec%0d_back_to_fetch", i), state_o, 0);
            chk($sformatf("vec%0d_illegal", i), illegal_op_o, tbl[i].done == 0);
        end

        // lw with a 3-cycle memory stall in MEM_READ.
        opcode_i = 6'h23;
        cyc(1'b1, 6'h23, 1'b1);
        chk("lw_decode", state_o, 1);
        cyc(1'b1, 6'h23, 1'b1);
        chk("lw_mem_addr", state_o, 2);
        for (int i = 0; i < 4; i++) begin
            cyc(i == 3, 6'h23, 1'b1);
            chk($sformatf("lw_mem_read_%0d", i), state_o, 3);
            chk($sformatf("lw_mem_read_ctl_%0d", i), act_ctl, exp_ctrl(3, i == 3, 6'h23));
        end
        cyc(1'b1, 6'h23, 1'b1);
        chk("lw_mem_wb_state", state_o, 4);
        chk("lw_mem_wb_ctl", act_ctl, exp_ctrl(4, 1'b1, 6'h23));
        cyc(1'b1, 6'h23, 1'b1);
        chk("lw_back_to_fetch", state_o, 0);

        // Illegal opcode: single-cycle pulse and no register write.
        opcode_i = 6'h3F;
        cyc(1'b1, 6'h3F, 1'b1);
        chk("ill_decode", state_o, 1);
        chk("ill_decode_rw", reg_write_o, 0);
        cyc(1'b0, 6'h3F, 1'b1);
        chk("ill_pulse", illegal_op_o, 1);
        chk("ill_fetch", state_o, 0);
        chk("ill_rw", reg_write_o, 0);
        cyc(1'b0, 6'h3F, 1'b1);
        chk("ill_pulse_end", illegal_op_o, 0);
        cyc(1'b1, 6'h00, 1'b1);
        chk("ill_resume_fetch", state_o, 0);

        // sw that never gets mem_ready: 16 MEM_WRITE cycles, then abort with bus_error.
        opcode_i = 6'h2B;
        cyc(1'b1, 6'h2B, 1'b1);
        cyc(1'b1, 6'h2B, 1'b1);
        chk("swto_mem_addr", state_o, 2);
        bad = 0;
        for (int i = 0; i < TO; i++) begin
            cyc(1'b0, 6'h2B, 1'b1);
            chk($sformatf("swto_mem_write_%0d", i), state_o, 5);
            if (mem_write_o !== 1'b1 || instr_done_o !== 1'b0 || bus_error_o !== 1'b0) bad++;
        end
        chk("swto_strobes_while_waiting", bad, 0);
        cyc(1'b0, 6'h2B, 1'b1);
        chk("swto_abort_fetch", state_o, 0);
        chk("swto_bus_error", bus_error_o, 1);
        chk("swto_no_done", instr_done_o, 0);
        cyc(1'b1, 6'h2B, 1'b1);
        chk("swto_bus_error_end", bus_error_o, 0);

        // sw whose mem_ready lands in the 16th (timeout) cycle completes normally.
        cyc(1'b1, 6'h2B, 1'b1);
        cyc(1'b1, 6'h2B, 1'b1);
        for (int i = 0; i < TO; i++) begin
            cyc(i == TO - 1, 6'h2B, 1'b1);
            chk($sformatf("swlate_mem_write_%0d", i), state_o, 5);
        end
        chk("swlate_done", instr_done_o, 1);
        cyc(1'b1, 6'h2B, 1'b1);
        chk("swlate_fetch", state_o, 0);
        chk("swlate_no_bus_error", bus_error_o, 0);

        // Reset asserted mid MEM_WRITE, then a stalled fetch that times out.
        cyc(1'b1, 6'h2B, 1'b1);
        cyc(1'b1, 6'h2B, 1'b1);
        cyc(1'b0, 6'h2B, 1'b1);
        cyc(1'b0, 6'h2B, 1'b1);
        chk("rstmid_in_mem_write", state_o, 5);
        cyc(1'b0, 6'h2B, 1'b0);
        chk("rstmid_mem_write_off", mem_write_o, 0);
        chk("rstmid_done_off", instr_done_o, 0);
        chk("rstmid_mem_read_off", mem_read_o, 0);
        mw_cnt = 0; be_cnt = 0;
        for (int i = 0; i <= TO; i++) begin
            cyc(1'b0, 6'h2B, 1'b1);
            if (i == 0) chk("rstmid_state_after", state_o, 0);
            mw_cnt += mem_write_o;
            if (i < TO) be_cnt += bus_error_o;
            else chk("rstmid_fetch_timeout", bus_error_o, 1);
        end
        chk("rstmid_no_mem_write", mw_cnt, 0);
        chk("rstmid_no_early_bus_error", be_cnt, 0);

        // Random instruction stream against the route-based model.
        cyc(1'b1, 6'h00, 1'b0);
        ms = 0; wcnt = 0; exp_ill = 1'b0; exp_berr = 1'b0; path.delete();
        op = 6'h00; mode = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 100 == 0) mode = $urandom_range(0, 2);
            if (ms == 1) begin
                if ($urandom_range(0, 9) == 0) op = 6'($urandom);
                else op = legal_ops[$urandom_range(0, 9)];
            end
            rdy = (mode == 0) ? ($urandom_range(0, 99) < 12) : ($urandom_range(0, 99) < 75);
            cyc(rdy, op, 1'b1);
            chk($sformatf("rnd%0d_state", n), state_o, ms);
            chk($sformatf("rnd%0d_ctl", n), act_ctl, exp_ctrl(ms, rdy, op));
            chk($sformatf("rnd%0d_illegal", n), illegal_op_o, exp_ill);
            chk($sformatf("rnd%0d_bus_error", n), bus_error_o, exp_berr);
            model_step(rdy, op);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
